xbar_out_stage: RTL and testbench



---
 rtl/xbar_out_stage_pkg.sv | 41 ++++
 rtl/xbar_out_stage_if.sv | 28 ++
 rtl/xbar_skid_buf.sv | 77 +++++++
 rtl/xbar_out_stage.sv | 62 ++++++
 tb/tb_xbar_out_stage.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/xbar_out_stage_pkg.sv
// Shared constants for the router output-port crossbar slice: port indices,
// legacy port-code mapping and skid-buffer state encodings.
package xbar_out_stage_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_IN_DEF     = 5;
  localparam int SEL_WIDTH_DEF  = 3;
  localparam int CNT_WIDTH_DEF  = 16;

  localparam logic [2:0] IDX_N    = 3'd0;
  localparam logic [2:0] IDX_E    = 3'd1;
  localparam logic [2:0] IDX_W    = 3'd2;
  localparam logic [2:0] IDX_S    = 3'd3;
  localparam logic [2:0] IDX_L    = 3'd4;
  localparam logic [2:0] SEL_IDLE = 3'd7;

  // One-hot port codes used by the older routing tables.
  localparam logic [4:0] PORT_CODE_N = 5'b00001;
  localparam logic [4:0] PORT_CODE_E = 5'b00010;
  localparam logic [4:0] PORT_CODE_W = 5'b00100;
  localparam logic [4:0] PORT_CODE_S = 5'b01000;
  localparam logic [4:0] PORT_CODE_L = 5'b10000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } xbar_state_e;

  function automatic logic [2:0] port_code_to_idx(input logic [4:0] code);
    case (code)
      PORT_CODE_N: port_code_to_idx = IDX_N;
      PORT_CODE_E: port_code_to_idx = IDX_E;
      PORT_CODE_W: port_code_to_idx = IDX_W;
      PORT_CODE_S: port_code_to_idx = IDX_S;
      PORT_CODE_L: port_code_to_idx = IDX_L;
      default:     port_code_to_idx = SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/xbar_out_stage_if.sv
// Input-side select/flit bundle and output-link handshake of one crossbar slice.
interface xbar_out_stage_if
  import xbar_out_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IN     = NUM_IN_DEF,
  parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
);
  logic [SEL_WIDTH-1:0]         sel_in;
  logic [NUM_IN*DATA_WIDTH-1:0] datain;
  logic [NUM_IN-1:0]            validin;
  logic [NUM_IN-1:0]            readyout;
  logic [DATA_WIDTH-1:0]        dataout;
  logic                         validout;
  logic                         readyin;
  logic [CNT_WIDTH-1:0]         flit_cnt;

  modport master (
    output sel_in, datain, validin, readyin,
    input  readyout, dataout, validout, flit_cnt
  );

  modport slave (
    input  sel_in, datain, validin, readyin,
    output readyout, dataout, validout, flit_cnt
  );
endinterface

// File: rtl/xbar_skid_buf.sv
// Two-entry valid/ready register stage; upstream ready depends only on state,
// never combinationally on downstream ready.
module xbar_skid_buf
  import xbar_out_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic                  o_acc_rdy,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data
);
  xbar_state_e           r_state, w_state_d;
  logic [DATA_WIDTH-1:0] r_main, w_main_d;
  logic [DATA_WIDTH-1:0] r_skid, w_skid_d;
  logic                  w_pop;

  assign o_acc_rdy = (r_state != ST_TWO);
  assign o_valid   = (r_state != ST_EMPTY);
  assign o_data    = r_main;
  assign w_pop     = o_valid & i_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_d;
      r_main  <= w_main_d;
      r_skid  <= w_skid_d;
    end
  end

  // Main register is zeroed on draining so the link reads 0 while invalid.
  always_comb begin
    w_state_d = r_state;
    w_main_d  = r_main;
    w_skid_d  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (i_push) begin
          w_state_d = ST_ONE;
          w_main_d  = i_data;
        end
      end
      ST_ONE: begin
        if (i_push && w_pop) begin
          w_main_d = i_data;
        end else if (i_push) begin
          w_state_d = ST_TWO;
          w_skid_d  = i_data;
        end else if (w_pop) begin
          w_state_d = ST_EMPTY;
          w_main_d  = '0;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_d = ST_ONE;
          w_main_d  = r_skid;
          w_skid_d  = '0;
        end
      end
      default: begin
        w_state_d = ST_EMPTY;
        w_main_d  = '0;
        w_skid_d  = '0;
      end
    endcase
  end

endmodule

// File: rtl/xbar_out_stage.sv
// N:1 output-port crossbar slice: index mux, per-input consume strobe,
// skid-buffered output link and forwarded-flit counter.
module xbar_out_stage
  import xbar_out_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_IN     = NUM_IN_DEF,
  parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rst,
  xbar_out_stage_if.slave bus
);
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_grant;
  logic                  w_acc_rdy;
  logic                  w_acc;
  logic                  w_snd;
  logic [CNT_WIDTH-1:0]  r_flit_cnt;

  // Compare-based select: idle codes match no input, so nothing X-indexes.
  always_comb begin
    w_sel_data = '0;
    w_grant    = 1'b0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (bus.sel_in == SEL_WIDTH'(i)) begin
        w_sel_data = bus.datain[i*DATA_WIDTH +: DATA_WIDTH];
        w_grant    = bus.validin[i];
      end
    end
  end

  // Gated by rst so the consume strobe is quiet while reset is held.
  assign w_acc = w_grant & w_acc_rdy & rst;
  assign w_snd = bus.validout & bus.readyin;

  always_comb begin
    bus.readyout = '0;
    for (int i = 0; i < NUM_IN; i++)
      bus.readyout[i] = w_acc & (bus.sel_in == SEL_WIDTH'(i));
  end

  xbar_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_acc),
    .i_data    (w_sel_data),
    .i_ready   (bus.readyin),
    .o_acc_rdy (w_acc_rdy),
    .o_valid   (bus.validout),
    .o_data    (bus.dataout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       r_flit_cnt <= '0;
    else if (w_snd) r_flit_cnt <= r_flit_cnt + 1'b1;
  end

  assign bus.flit_cnt = r_flit_cnt;

endmodule

// File: tb/tb_xbar_out_stage.sv
// Directed bench for xbar_out_stage; a queue of accepted-but-unsent flits is
// the reference for occupancy, output order, consume strobes and the counter.
module tb_xbar_out_stage;
  localparam int DW = 32;
  localparam int NI = 5;
  localparam int SW = 3;
  localparam int CW = 16;

  logic clk;
  logic rst;
  xbar_out_stage_if #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) bus ();

  xbar_out_stage #(.DATA_WIDTH(DW), .NUM_IN(NI), .SEL_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Checker: compares outputs against the queue, then advances it for the coming edge.
  always @(negedge clk) begin
    logic          acc;
    logic [NI-1:0] exp_ry;
    logic [DW-1:0] exp_d;
    if (!rst) begin
      check("rst_validout", 64'(bus.validout), 64'd0);
      check("rst_dataout",  64'(bus.dataout),  64'd0);
      check("rst_readyout", 64'(bus.readyout), 64'd0);
      check("rst_flit_cnt", 64'(bus.flit_cnt), 64'd0);
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      exp_d = (exp_q.size() != 0) ? exp_q[0] : '0;
      check("validout", 64'(bus.validout), 64'(exp_q.size() != 0));
      check("dataout",  64'(bus.dataout),  64'(exp_d));
      check("flit_cnt", 64'(bus.flit_cnt), 64'(exp_cnt));
      acc = 1'b0;
      if (int'(bus.sel_in) < NI)
        acc = bus.validin[int'(bus.sel_in)] && (exp_q.size() < 2);
      exp_ry = acc ? (NI'(1) << bus.sel_in) : '0;
      check("readyout", 64'(bus.readyout), 64'(exp_ry));
      if (exp_q.size() != 0 && bus.readyin) begin
        void'(exp_q.pop_front());
        exp_cnt = exp_cnt + 1'b1;
      end
      if (acc) exp_q.push_back(bus.datain[int'(bus.sel_in)*DW +: DW]);
    end
  end

  task automatic idle(input int n);
    bus.sel_in  = 3'd7;
    bus.validin = NI'($urandom);
    bus.datain  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Present one flit on input idx until the slice consumes it (bounded).
  task automatic put(input int idx, input logic [DW-1:0] d);
    bus.sel_in  = SW'(idx);
    bus.validin = NI'(1) << idx;
    bus.datain  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    bus.datain[idx*DW +: DW] = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.readyout[idx]) begin
        @(posedge clk); #1;
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL put_timeout: flit %0h on input %0d never consumed", d, idx);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0;
    bus.readyin = 1'b1;
    repeat (3) begin
      bus.sel_in  = SW'($urandom_range(0, 4));
      bus.validin = NI'($urandom);
      bus.datain  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      bus.readyin = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.readyin = 1'b1;
    idle(0);
    rst = 1'b1;
    idle(10);

    put(1, 32'hDEAD_BEEF);
    idle(3);

    for (int i = 1; i <= 8; i++) put(4, DW'(i));
    idle(3);

    put(0, 32'hAAAA_0001);
    bus.readyin = 1'b0;
    put(0, 32'hBBBB_0002);
    fork
      put(0, 32'hCCCC_0003);
      begin repeat (4) @(posedge clk); #1 bus.readyin = 1'b1; end
    join
    idle(4);

    bus.sel_in = 3'd2; bus.validin = 5'b11011;
    repeat (3) begin @(posedge clk); #1; end
    bus.sel_in = 3'd5; bus.validin = 5'b11111;
    repeat (3) begin @(posedge clk); #1; end
    bus.sel_in = 3'd6;
    repeat (2) begin @(posedge clk); #1; end

    bus.readyin = 1'b0;
    put(3, 32'h1111_0001);
    put(3, 32'h2222_0002);
    #1 rst = 1'b0;
    #1;
    check("async_validout", 64'(bus.validout), 64'd0);
    check("async_dataout",  64'(bus.dataout),  64'd0);
    check("async_readyout", 64'(bus.readyout), 64'd0);
    check("async_flit_cnt", 64'(bus.flit_cnt), 64'd0);
    idle(0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.readyin = 1'b1;
    put(2, 32'h0000_00A1);
    put(2, 32'h0000_00A2);
    put(2, 32'h0000_00A3);
    idle(4);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
